pll_lock_supervisor: RTL and testbench

Supervises the lock output of a Gowin rPLL wrapper and is the consumer end of the PLL clkin/lock interface. It runs on the PLL reference clock. It drives the PLL RESET pin, qualifies lock (lock must stay stable, and a timeout triggers a retry), and produces a clean system reset plus status. One instance sits beside each PLL wrapper at the top level.

---
 rtl/pll_sup_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_supervisor.sv | 114 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and constants for the PLL lock supervisor.
//   state_t      : supervisor state, 2-bit encoding (PLL_RST=0, WAIT_LOCK=1, RUN=2)
//   DEF_*        : default timing constants for a 27 MHz reference clock
//   timer_width(): width of the internal timers, sized from the largest limit
// -----------------------------------------------------------------------------
package pll_sup_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int DEF_RST_CYCLES    = 27;     // 1 us
    localparam int DEF_STABLE_CYCLES = 2700;   // 100 us
    localparam int DEF_LOCK_TIMEOUT  = 27000;  // 1 ms
    localparam int DEF_CNT_W         = 8;

    // Timers only ever hold values up to (limit-1), so $clog2(limit) bits are
    // enough; a limit of 1 still needs a 1-bit register.
    function automatic int timer_width(input int rst_cycles,
                                       input int stable_cycles,
                                       input int lock_timeout);
        int m;
        m = rst_cycles;
        if (stable_cycles > m) m = stable_cycles;
        if (lock_timeout > m) m = lock_timeout;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Drives the rPLL RESET pin, qualifies the PLL lock output and produces a
// clean downstream reset plus status. Runs entirely on the PLL reference clock.
//   clkin     : PLL reference clock, the only clock
//   reset     : synchronous, active-high
//   lock      : raw PLL lock, asynchronous (synchronized internally)
//   pll_reset : high exactly while in PLL_RST
//   sys_reset : active-high downstream reset, inverse of ready
//   ready     : high exactly while in RUN
//   state     : current state (0=PLL_RST, 1=WAIT_LOCK, 2=RUN)
//   retry_cnt : saturating count of lock timeouts
//   loss_cnt  : saturating count of lock drops while in RUN
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             lock,
    output logic             pll_reset,
    output logic             sys_reset,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int TW = timer_width(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);

    logic          lock_s;
    state_t        state_q;
    state_t        state_d;
    // tmo_cnt doubles as the reset-pulse timer in PLL_RST.
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] stable_cnt;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clkin),
        .reset (reset),
        .d     (lock),
        .q     (lock_s)
    );

    // Next state. In WAIT_LOCK the qualification check comes first so that a
    // lock qualifying on the timeout cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PLL_RST: begin
                if (tmo_cnt == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s && (stable_cnt == STABLE_LAST)) state_d = RUN;
                else if (tmo_cnt == TMO_LAST)              state_d = PLL_RST;
            end
            RUN: begin
                if (!lock_s) state_d = PLL_RST;
            end
            default: state_d = PLL_RST;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as state. Timers restart on every state change; neither can wrap
    // because each state is left on the cycle its timer reaches its limit.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= PLL_RST;
            pll_reset  <= 1'b1;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            tmo_cnt    <= '0;
            stable_cnt <= '0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            pll_reset <= (state_d == PLL_RST);
            ready     <= (state_d == RUN);
            sys_reset <= (state_d != RUN);

            if (state_d != state_q) begin
                tmo_cnt    <= '0;
                stable_cnt <= '0;
            end else if (state_q == PLL_RST) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else if (state_q == WAIT_LOCK) begin
                tmo_cnt    <= tmo_cnt + TW'(1);
                stable_cnt <= lock_s ? (stable_cnt + TW'(1)) : '0;
            end

            if ((state_q == WAIT_LOCK) && (state_d == PLL_RST) && (retry_cnt != '1))
                retry_cnt <= retry_cnt + CNT_W'(1);

            if ((state_q == RUN) && (state_d == PLL_RST) && (loss_cnt != '1))
                loss_cnt <= loss_cnt + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed scenarios plus randomized lock waveforms. A behavioural model counts
// how long the block has spent in each phase and how long lock has been
// continuously high, and pushes the expected outputs for every cycle into a
// queue that is compared against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int R   = 4;
    localparam int S   = 8;
    localparam int T   = 32;
    localparam int W   = 8;
    localparam int SAT = (1 << W) - 1;
    localparam int EW  = 2 + 3 + 2 * W;

    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;

    // ---------------- clock / reset ----------------
    logic         clkin = 1'b0;
    logic         reset = 1'b1;
    logic         lock  = 1'b0;
    logic         pll_reset;
    logic         sys_reset;
    logic         ready;
    logic [1:0]   state;
    logic [W-1:0] retry_cnt;
    logic [W-1:0] loss_cnt;

    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .RST_CYCLES    (R),
        .STABLE_CYCLES (S),
        .LOCK_TIMEOUT  (T),
        .CNT_W         (W)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .lock      (lock),
        .pll_reset (pll_reset),
        .sys_reset (sys_reset),
        .ready     (ready),
        .state     (state),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    // ---------------- behavioural model ----------------
    int   m_mode   = M_RST;
    int   m_age    = 0;   // cycles completed in the current phase
    int   m_streak = 0;   // consecutive synchronized-high samples in WAIT
    int   m_retry  = 0;
    int   m_loss   = 0;
    logic m_s1     = 1'b0;
    logic m_s2     = 1'b0;

    logic [EW-1:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic logic [EW-1:0] pack(input int st, input int rc, input int lc);
        logic rd;
        rd = (st == M_RUN);
        return {2'(st), (st == M_RST), ~rd, rd, W'(rc), W'(lc)};
    endfunction

    task automatic model_update(input logic lk, input logic rst);
        logic ls;
        ls = m_s2;   // value the block sees at this edge (two edges old)
        if (rst) begin
            m_mode = M_RST; m_age = 0; m_streak = 0;
            m_retry = 0; m_loss = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            m_s2 = m_s1;
            m_s1 = lk;
            case (m_mode)
                M_RST: begin
                    m_age++;
                    if (m_age == R) begin m_mode = M_WAIT; m_age = 0; m_streak = 0; end
                end
                M_WAIT: begin
                    m_age++;
                    m_streak = ls ? m_streak + 1 : 0;
                    if (m_streak == S) begin
                        m_mode = M_RUN; m_age = 0;
                    end else if (m_age == T) begin
                        m_mode = M_RST; m_age = 0;
                        if (m_retry < SAT) m_retry++;
                    end
                end
                default: begin
                    if (!ls) begin
                        m_mode = M_RST; m_age = 0;
                        if (m_loss < SAT) m_loss++;
                    end
                end
            endcase
        end
        exp_q.push_back(pack(m_mode, m_retry, m_loss));
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_cycle();
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        got = {state, pll_reset, sys_reset, ready, retry_cnt, loss_cnt};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL cycle_%0d: no expectation queued, got %h", cyc, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL cycle_%0d: got {state,pll,sys,rdy,retry,loss}=%h required %h (state %0d retry %0d loss %0d)",
                         cyc, got, exp, state, retry_cnt, loss_cnt);
            end
        end
    endtask

    task automatic check_lit(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic lk, input logic rst);
        lock  = lk;
        reset = rst;
        @(posedge clkin);
        model_update(lk, rst);
        @(negedge clkin);
        check_cycle();
        cyc++;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int p_at, r_at, mp_at, mr_at;

        // 1: lock high from the start; release timing
        repeat (3) step(1'b1, 1'b1);
        p_at = -1; r_at = -1; mp_at = -1; mr_at = -1;
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, 1'b0);
            if (p_at < 0 && !pll_reset)       p_at = n;
            if (r_at < 0 && ready)            r_at = n;
            if (mp_at < 0 && m_mode != M_RST) mp_at = n;
            if (mr_at < 0 && m_mode == M_RUN) mr_at = n;
        end
        check_lit("t1_pll_reset_release", p_at, 4);
        check_lit("t1_model_pll_release", mp_at, 4);
        check_lit("t1_ready_rise", r_at, 12);
        check_lit("t1_model_ready_rise", mr_at, 12);
        check_lit("t1_state_run", int'(state), 2);
        check_lit("t1_retry_zero", int'(retry_cnt), 0);

        // 2: lock never comes; retry loop and saturation
        repeat (2) step(1'b0, 1'b1);
        for (int n = 1; n <= 300 * (T + R); n++) begin
            step(1'b0, 1'b0);
            if (n == 35)  begin check_lit("t2_retry_before_first", int'(retry_cnt), 0);
                                check_lit("t2_state_wait", int'(state), 1); end
            if (n == 36)  begin check_lit("t2_retry_1", int'(retry_cnt), 1);
                                check_lit("t2_state_rst", int'(state), 0); end
            if (n == 72)  check_lit("t2_retry_2", int'(retry_cnt), 2);
            if (n == 108) check_lit("t2_retry_3", int'(retry_cnt), 3);
        end
        check_lit("t2_retry_saturated", int'(retry_cnt), 255);
        check_lit("t2_model_retry_saturated", m_retry, 255);
        check_lit("t2_loss_zero", int'(loss_cnt), 0);

        // 3: lock high 7, low 1, high 8+ during WAIT_LOCK
        repeat (2) step(1'b0, 1'b1);
        r_at = -1;
        for (int n = 1; n <= 30; n++) begin
            step((n >= 5 && n <= 11) || (n >= 13), 1'b0);
            if (r_at < 0 && ready) r_at = n;
        end
        check_lit("t3_ready_after_second_run", r_at, 22);

        // 4: one-cycle drop while in RUN, then relock
        r_at = -1;
        for (int n = 1; n <= 25; n++) begin
            step(n != 3, 1'b0);
            if (n == 4) check_lit("t4_sys_reset_edge2", int'(sys_reset), 0);
            if (n == 5) begin
                check_lit("t4_sys_reset_edge3", int'(sys_reset), 1);
                check_lit("t4_state_rst", int'(state), 0);
                check_lit("t4_loss_1", int'(loss_cnt), 1);
            end
            if (r_at < 0 && n > 5 && ready) r_at = n;
        end
        check_lit("t4_relock_ready", r_at, 17);

        // 5: qualification on the timeout cycle, and one cycle too late
        repeat (2) step(1'b0, 1'b1);
        for (int n = 1; n <= 40; n++) begin
            step(n >= 27, 1'b0);
            if (n == 36) begin
                check_lit("t5_tie_state_run", int'(state), 2);
                check_lit("t5_tie_retry_unchanged", int'(retry_cnt), 0);
            end
        end
        repeat (2) step(1'b0, 1'b1);
        for (int n = 1; n <= 40; n++) begin
            step(n >= 28, 1'b0);
            if (n == 36) begin
                check_lit("t5_late_state_rst", int'(state), 0);
                check_lit("t5_late_retry_1", int'(retry_cnt), 1);
            end
        end

        // 6: reset while in RUN with both counters non-zero
        repeat (2) step(1'b0, 1'b1);
        repeat (36) step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        check_lit("t6_pre_retry", int'(retry_cnt), 1);
        check_lit("t6_pre_loss", int'(loss_cnt), 1);
        check_lit("t6_pre_ready", int'(ready), 1);
        step(1'b1, 1'b1);
        check_lit("t6_state", int'(state), 0);
        check_lit("t6_pll_reset", int'(pll_reset), 1);
        check_lit("t6_sys_reset", int'(sys_reset), 1);
        check_lit("t6_retry_cleared", int'(retry_cnt), 0);
        check_lit("t6_loss_cleared", int'(loss_cnt), 0);
        repeat (5) step(1'b1, 1'b0);

        // random lock waveforms with occasional resets
        begin
            int   seg;
            logic lv;
            seg = 0;
            lv  = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if (seg == 0) begin
                    lv  = ~lv;
                    seg = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
                end
                seg--;
                step(lv, $urandom_range(0, 499) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
